maxpool_stream: RTL and testbench

Streaming, parametrised K×K max-pooling stage for the CNN datapath. It accepts one signed activation per cycle in raster order over a single-channel IMG_W×IMG_H feature map and emits one pooled value per non-overlapping K×K window (stride K), also in raster order. It sits between the convolution output and the next layer or the SoC buffer. Valid/ready handshakes on both sides replace the fixed-phase, clock-divider-driven 2×2 pooling stage.

---
 rtl/maxpool_stream_if.sv | 25 ++
 rtl/maxpool_stream.sv | 136 +++++++++++++
 tb/tb_maxpool_stream.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_stream_if.sv
// Purpose : valid/ready stream bundle for maxpool_stream (pixel input side and pooled output side).
// Latency : none, wires only.
// Backpr. : in_ready / out_ready carry backpressure in opposite directions.
// Ports   : master = upstream/downstream environment, slave = pooling stage.
interface maxpool_stream_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/maxpool_stream.sv
// Purpose : streaming KxK stride-K signed max-pool over a raster-ordered IMG_W x IMG_H map.
// Latency : result valid 1 cycle after the accept of a window's bottom-right pixel.
// Backpr. : single output register; in_ready = !clear & (!out_valid | out_ready).
// Ports   : clk, rst (async active-low), clear (sync frame restart), bus (slave stream bundle).
module maxpool_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL_K = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  maxpool_stream_if.slave bus
);

  localparam int COLS = IMG_W / POOL_K;
  localparam int KW   = $clog2(POOL_K);
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW   = $clog2(IMG_H);
  localparam logic [KW-1:0] K_LAST = KW'(POOL_K - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // x is tracked as (c, kx) and y as (y, ky) so no divider is needed.
  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0] c_q, c_d;
  logic [YW-1:0] y_q, y_d;

  logic signed [DATA_W-1:0] hmax_q, hmax_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;

  // Column partial maxima; not reset, every entry is rewritten on window row 0.
  logic signed [DATA_W-1:0] lbuf [COLS];

  logic                     in_ready, accept, kx_end, ky_end, row_end, buf_we, win_done;
  logic signed [DATA_W-1:0] pix, h, buf_rd, col_max, buf_wd;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_ready = !clear && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign pix      = bus.in_data;

  assign kx_end   = (kx_q == K_LAST);
  assign ky_end   = (ky_q == K_LAST);
  assign row_end  = kx_end && (c_q == C_LAST);
  assign win_done = accept && kx_end && ky_end;

  assign h        = (kx_q == '0) ? pix : smax(hmax_q, pix);
  assign buf_rd   = lbuf[c_q];
  assign col_max  = smax(buf_rd, h);
  assign buf_we   = accept && kx_end && !ky_end;
  assign buf_wd   = (ky_q == '0) ? h : col_max;

  always_comb begin
    kx_d        = kx_q;
    ky_d        = ky_q;
    c_d         = c_q;
    y_d         = y_q;
    hmax_d      = hmax_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (accept) begin
      hmax_d = h;
      kx_d   = kx_end ? '0 : kx_q + 1'b1;
      if (kx_end) begin
        c_d = (c_q == C_LAST) ? '0 : c_q + 1'b1;
      end
      if (row_end) begin
        ky_d = ky_end ? '0 : ky_q + 1'b1;
        y_d  = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end
    end

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // A new result may load in the same cycle the previous one is taken.
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = col_max;
      out_last_d  = (c_q == C_LAST) && (y_q == Y_LAST);
    end

    if (clear) begin
      kx_d        = '0;
      ky_d        = '0;
      c_d         = '0;
      y_d         = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      lbuf[c_q] <= buf_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kx_q        <= '0;
      ky_q        <= '0;
      c_q         <= '0;
      y_q         <= '0;
      hmax_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      c_q         <= c_d;
      y_q         <= y_d;
      hmax_q      <= hmax_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Purpose : self-checking bench for maxpool_stream, K=2 4x4 and K=4 8x4 instances.
// Latency : checks 1-cycle result latency against a window-level reference model.
// Backpr. : drives out_ready stalls and random in_valid gaps.
module tb_maxpool_stream;

  logic clk = 1'b0;
  logic rst;
  logic clr2, clr4;
  always #5 clk = ~clk;

  maxpool_stream_if #(.DATA_W(8)) if2 ();
  maxpool_stream_if #(.DATA_W(8)) if4 ();

  maxpool_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL_K(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clr2), .bus(if2)
  );
  maxpool_stream #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .POOL_K(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clr4), .bus(if4)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] pix [32];
  logic [7:0] q2d [$];
  logic       q2l [$];
  logic [7:0] q4d [$];
  logic       q4l [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: every KxK window whose bottom-right pixel lies among the first n
  // pixels of the frame yields the signed maximum of its K*K pixels.
  task automatic model(input int sel, input int w, input int hgt, input int k, input int n);
    for (int wr = 0; wr < hgt / k; wr++) begin
      for (int wc = 0; wc < w / k; wc++) begin
        int br, m, v;
        logic lst;
        br = (wr * k + k - 1) * w + wc * k + k - 1;
        if (br < n) begin
          m = -100000;
          for (int dy = 0; dy < k; dy++)
            for (int dx = 0; dx < k; dx++) begin
              v = int'($signed(pix[(wr * k + dy) * w + wc * k + dx]));
              if (v > m) m = v;
            end
          lst = (wr == hgt / k - 1) && (wc == w / k - 1);
          if (sel == 2) begin q2d.push_back(8'(m)); q2l.push_back(lst); end
          else          begin q4d.push_back(8'(m)); q4l.push_back(lst); end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst && if2.out_valid && if2.out_ready) begin
      if (q2d.size() == 0) chk("m2_spurious", 32'(if2.out_valid), 32'd0);
      else begin
        chk("m2_data", 32'(if2.out_data), 32'(q2d.pop_front()));
        chk("m2_last", 32'(if2.out_last), 32'(q2l.pop_front()));
      end
    end
    if (rst && if4.out_valid && if4.out_ready) begin
      if (q4d.size() == 0) chk("m4_spurious", 32'(if4.out_valid), 32'd0);
      else begin
        chk("m4_data", 32'(if4.out_data), 32'(q4d.pop_front()));
        chk("m4_last", 32'(if4.out_last), 32'(q4l.pop_front()));
      end
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 2) ? if2.in_ready : if4.in_ready;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    if (sel == 2) begin if2.in_valid = v; if2.in_data = d; end
    else          begin if4.in_valid = v; if4.in_data = d; end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int sel, input logic [7:0] d, input int gap);
    int t;
    set_in(sel, 1'b0, d);
    repeat (gap) begin @(posedge clk); #1; end
    set_in(sel, 1'b1, d);
    t = 0;
    @(negedge clk);
    while (!rdy(sel) && t < 200) begin @(negedge clk); t++; end
    if (!rdy(sel)) chk("in_ready_timeout", 32'(rdy(sel)), 32'd1);
    @(posedge clk); #1;
    set_in(sel, 1'b0, d);
  endtask

  task automatic run_frame(input int sel, input int n, input int maxgap);
    for (int i = 0; i < n; i++)
      send(sel, pix[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q2d.size() != 0 || q4d.size() != 0) && t < 100) begin @(posedge clk); #1; t++; end
    chk(tag, 32'(q2d.size() + q4d.size()), 32'd0);
  endtask

  initial begin
    logic is_end;
    logic done;
    int   t;
    rst = 1'b1; clr2 = 1'b0; clr4 = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_ovld", 32'(if2.out_valid), 32'd0);
    chk("rst_odat", 32'(if2.out_data), 32'd0);
    chk("rst_olast", 32'(if2.out_last), 32'd0);
    #10 rst = 1'b1;
    @(negedge clk);
    chk("rst_inrdy2", 32'(if2.in_ready), 32'd1);
    chk("rst_inrdy4", 32'(if4.in_ready), 32'd1);
    @(posedge clk); #1;

    // Ramp 0..15, no stalls: results 5,7,13,15 one cycle after their pixels.
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    model(2, 4, 4, 2, 16);
    for (int i = 0; i < 16; i++) begin
      send(2, pix[i], 0);
      is_end = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      chk("lat_vld", 32'(if2.out_valid), 32'(is_end));
      if (is_end) begin
        chk("lat_dat", 32'(if2.out_data), 32'(i));
        chk("lat_last", 32'(if2.out_last), 32'(i == 15));
      end
    end
    drain("ramp_drain");

    // Signed comparisons in the first two windows.
    for (int i = 0; i < 16; i++) pix[i] = 8'($urandom);
    pix[0] = 8'h80; pix[1] = 8'hFF; pix[4] = 8'h81; pix[5] = 8'h01;
    pix[2] = 8'h80; pix[3] = 8'h90; pix[6] = 8'hA0; pix[7] = 8'hFF;
    model(2, 4, 4, 2, 16);
    for (int i = 0; i < 16; i++) begin
      send(2, pix[i], 0);
      if (i == 5) chk("sgn_w0", 32'(if2.out_data), 32'h01);
      if (i == 7) chk("sgn_w1", 32'(if2.out_data), 32'hFF);
    end
    drain("sgn_drain");

    // Backpressure: first result held, input must stall, nothing lost.
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    model(2, 4, 4, 2, 16);
    if2.out_ready = 1'b0;
    fork
      run_frame(2, 16, 0);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!if2.out_valid && t < 100);
        chk("bp_vld", 32'(if2.out_valid), 32'd1);
        repeat (4) begin
          @(negedge clk);
          chk("bp_hold", 32'(if2.out_data), 32'd5);
          chk("bp_inrdy", 32'(if2.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        if2.out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Two back-to-back random frames with input gaps and random out_ready.
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          for (int i = 0; i < 16; i++) pix[i] = 8'($urandom);
          model(2, 4, 4, 2, 16);
          run_frame(2, 16, 2);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if2.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    if2.out_ready = 1'b1;
    drain("rnd_drain");

    // Partial frame with large values, clear mid row 2, then a fresh ramp.
    for (int i = 0; i < 16; i++) pix[i] = 8'(i + 100);
    model(2, 4, 4, 2, 10);
    run_frame(2, 10, 0);
    drain("clr_pre_drain");
    clr2 = 1'b1; if2.in_valid = 1'b1; if2.in_data = 8'd99;
    @(negedge clk);
    chk("clr_inrdy", 32'(if2.in_ready), 32'd0);
    @(posedge clk); #1;
    clr2 = 1'b0; if2.in_valid = 1'b0;
    chk("clr_ovld", 32'(if2.out_valid), 32'd0);
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    model(2, 4, 4, 2, 16);
    run_frame(2, 16, 0);
    drain("clr_post_drain");

    // POOL_K=4 on an 8x4 ramp: 27, 31.
    for (int i = 0; i < 32; i++) pix[i] = 8'(i);
    model(4, 8, 4, 4, 32);
    run_frame(4, 32, 1);
    drain("k4_drain");

    // Async reset while a result is pending.
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    if2.out_ready = 1'b0;
    run_frame(2, 6, 0);
    chk("arst_pre_vld", 32'(if2.out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ovld", 32'(if2.out_valid), 32'd0);
    chk("arst_odat", 32'(if2.out_data), 32'd0);
    chk("arst_olast", 32'(if2.out_last), 32'd0);
    if2.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model(2, 4, 4, 2, 16);
    run_frame(2, 16, 0);
    drain("arst_post_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
